// File: rtl/instr_encode_pkg.sv
// Shared constants for the RV32I instruction encoder: format codes, opcodes and the NOP word.
package instr_encode_pkg;

  localparam logic [2:0] FmtR       = 3'd0;
  localparam logic [2:0] FmtI       = 3'd1;
  localparam logic [2:0] FmtIshift  = 3'd2;
  localparam logic [2:0] FmtS       = 3'd3;
  localparam logic [2:0] FmtB       = 3'd4;
  localparam logic [2:0] FmtU       = 3'd5;
  localparam logic [2:0] FmtJ       = 3'd6;
  localparam logic [2:0] FmtIllegal = 3'd7;

  localparam logic [6:0] OpcLoad    = 7'h03;
  localparam logic [6:0] OpcMiscMem = 7'h0f;
  localparam logic [6:0] OpcOpImm   = 7'h13;
  localparam logic [6:0] OpcAuipc   = 7'h17;
  localparam logic [6:0] OpcStore   = 7'h23;
  localparam logic [6:0] OpcOp      = 7'h33;
  localparam logic [6:0] OpcLui     = 7'h37;
  localparam logic [6:0] OpcBranch  = 7'h63;
  localparam logic [6:0] OpcJalr    = 7'h67;
  localparam logic [6:0] OpcJal     = 7'h6f;
  localparam logic [6:0] OpcSystem  = 7'h73;

  localparam logic [31:0] Nop = 32'h00000013;

  // Buffer entry: {imm_err, instr}.
  localparam int unsigned EntryW = 33;

endpackage

// File: rtl/instr_encode_fifo.sv
// Valid/ready FIFO holding encoded words; pointers wrap modulo DEPTH, head reads as 0 when empty.
module instr_encode_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] wdata,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rdata,
  output logic             pop
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OccW = $clog2(DEPTH + 1);

  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [OccW-1:0]  occ_q, occ_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign wr_ready = (occ_q < OccW'(DEPTH));
  assign rd_valid = (occ_q != '0);
  assign push     = wr_valid & wr_ready;
  assign pop      = rd_valid & rd_ready;
  assign rdata    = rd_valid ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    occ_d = occ_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + OccW'(1);
      2'b01:   occ_d = occ_q - OccW'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      occ_q <= occ_d;
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
    end
  end

  // Storage needs no reset: the head is masked whenever the buffer is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/instr_encode.sv
// RV32I instruction encoder with an output FIFO and transfer counter.
// Optional immediate range checking is enabled by defining INSTR_ENCODE_RANGE_CHECK_EN.
module instr_encode
  import instr_encode_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       fmt,
  input  logic [6:0]       opcode,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic [31:0]      imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      instr,
  output logic             imm_err,
  output logic [CNT_W-1:0] enc_count
);

  logic [31:0]       enc_word;
  logic              fmt_err;
  logic              range_err;
  logic [EntryW-1:0] head;
  logic              pop;
  logic [CNT_W-1:0]  enc_count_q;

  always_comb begin
    enc_word = Nop;
    fmt_err  = 1'b0;
    case (fmt)
      FmtR:      enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
      FmtI:      enc_word = {imm[11:0], rs1, funct3, rd, opcode};
      FmtIshift: enc_word = {funct7, imm[4:0], rs1, funct3, rd, opcode};
      FmtS:      enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FmtB:      enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      FmtU:      enc_word = {imm[31:12], rd, opcode};
      FmtJ:      enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: begin
        enc_word = Nop;
        fmt_err  = 1'b1;
      end
    endcase
  end

`ifdef INSTR_ENCODE_RANGE_CHECK_EN
  // Sign-extension check: the dropped upper bits must all equal the kept sign bit.
  always_comb begin
    range_err = 1'b0;
    case (fmt)
      FmtI, FmtS: range_err = !((&imm[31:11]) || !(|imm[31:11]));
      FmtB:       range_err = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
      FmtJ:       range_err = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
      FmtU:       range_err = |imm[11:0];
      FmtIshift:  range_err = |imm[31:5];
      default:    range_err = 1'b0;
    endcase
  end
`else
  assign range_err = 1'b0;
`endif

  instr_encode_fifo #(
    .WIDTH(EntryW),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (in_valid),
    .wr_ready (in_ready),
    .wdata    ({fmt_err | range_err, enc_word}),
    .rd_valid (out_valid),
    .rd_ready (out_ready),
    .rdata    (head),
    .pop      (pop)
  );

  assign instr   = head[31:0];
  assign imm_err = head[32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_count_q <= '0;
    end else if (pop) begin
      enc_count_q <= enc_count_q + CNT_W'(1);
    end
  end

  assign enc_count = enc_count_q;

endmodule
